// File: rtl/mem_req_issuer_if.sv
// Bundle of issuer-side signals: commit port, load request port, memory
// store/load ports, memory response and the CDB writeback.
interface mem_req_issuer_if #(
    parameter int ROB_W  = 5,
    parameter int PREG_W = 7
);
    logic              flush;
    logic              commit_valid;
    logic [31:0]       commit_addr;
    logic [31:0]       commit_data;
    logic              commit_sh;
    logic [ROB_W-1:0]  commit_rob;
    logic              sb_full;
    logic              sb_empty;
    logic              ld_req_valid;
    logic              ld_req_ready;
    logic [31:0]       ld_addr;
    logic [2:0]        ld_func3;
    logic [PREG_W-1:0] ld_pd;
    logic [ROB_W-1:0]  ld_rob;
    logic              store_wb;
    logic [31:0]       st_addr;
    logic [31:0]       st_data;
    logic              st_sh;
    logic              load_mem;
    logic [31:0]       mem_ld_addr;
    logic [2:0]        mem_ld_func3;
    logic [ROB_W-1:0]  mem_ld_rob;
    logic              mem_valid;
    logic [31:0]       mem_data;
    logic [ROB_W-1:0]  mem_rob;
    logic              wb_valid;
    logic [31:0]       wb_data;
    logic [PREG_W-1:0] wb_pd;
    logic [ROB_W-1:0]  wb_rob;
    logic              dup_tag_err;

    // ld_req: a request transfers on a cycle where ld_req_valid && ld_req_ready;
    // the requester holds valid and payload stable until that cycle.
    modport master (
        output flush, commit_valid, commit_addr, commit_data, commit_sh, commit_rob,
               ld_req_valid, ld_addr, ld_func3, ld_pd, ld_rob, mem_valid, mem_data, mem_rob,
        input  sb_full, sb_empty, ld_req_ready, store_wb, st_addr, st_data, st_sh,
               load_mem, mem_ld_addr, mem_ld_func3, mem_ld_rob,
               wb_valid, wb_data, wb_pd, wb_rob, dup_tag_err
    );
    modport slave (
        input  flush, commit_valid, commit_addr, commit_data, commit_sh, commit_rob,
               ld_req_valid, ld_addr, ld_func3, ld_pd, ld_rob, mem_valid, mem_data, mem_rob,
        output sb_full, sb_empty, ld_req_ready, store_wb, st_addr, st_data, st_sh,
               load_mem, mem_ld_addr, mem_ld_func3, mem_ld_rob,
               wb_valid, wb_data, wb_pd, wb_rob, dup_tag_err
    );
endinterface

// File: rtl/mem_req_issuer.sv
// Memory request issuer: committed-store FIFO plus a single held load that
// waits out any overlapping buffered store, then writes back toward the CDB.
module mem_req_issuer #(
    parameter int SB_DEPTH = 4,
    parameter int ROB_W    = 5,
    parameter int PREG_W   = 7
) (
    input  logic                clk,
    input  logic                reset,
    mem_req_issuer_if.slave     bus,
    output logic [1:0]          o_dbg_state
);
    localparam int              PTR_W   = $clog2(SB_DEPTH);
    localparam logic [PTR_W:0]  CNT_MAX = (PTR_W+1)'(SB_DEPTH);
    localparam logic [2:0]      F3_LW   = 3'b010;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_HELD = 2'd1, S_WAIT = 2'd2} state_t;
    state_t r_state, w_state_nxt;

    logic [31:0]       r_sb_addr [SB_DEPTH];
    logic [31:0]       r_sb_data [SB_DEPTH];
    logic              r_sb_sh   [SB_DEPTH];
    logic [PTR_W-1:0]  r_head, r_tail;
    logic [PTR_W:0]    r_count, w_count_nxt;
    logic              r_sb_full, r_sb_empty;

    logic [31:0]       r_ld_addr;
    logic [2:0]        r_ld_func3;
    logic [PREG_W-1:0] r_ld_pd;
    logic [ROB_W-1:0]  r_ld_rob;
    logic              r_squash;
    logic [ROB_W-1:0]  r_last_rob;
    logic              r_dup_err;
    logic              r_wb_valid;
    logic [31:0]       r_wb_data;
    logic [PREG_W-1:0] r_wb_pd;
    logic [ROB_W-1:0]  r_wb_rob;

    logic              w_full, w_conflict, w_issue_ld, w_issue_st, w_push, w_resp, w_accept;
    logic [31:0]       w_ld_hi;
    logic [31:0]       w_st_hi [SB_DEPTH];
    logic [PTR_W-1:0]  w_off   [SB_DEPTH];

    // Entry i is live when its distance from head is below count; the head
    // entry stays in the test even in the cycle it pops.
    always_comb begin
        w_ld_hi    = r_ld_addr + ((r_ld_func3 == F3_LW) ? 32'd3 : 32'd0);
        w_conflict = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            w_off[i]   = PTR_W'(i) - r_head;
            w_st_hi[i] = r_sb_addr[i] + (r_sb_sh[i] ? 32'd1 : 32'd3);
            if (({1'b0, w_off[i]} < r_count) && (r_ld_addr <= w_st_hi[i]) &&
                (r_sb_addr[i] <= w_ld_hi))
                w_conflict = 1'b1;
        end
    end

    assign w_full     = (r_count == CNT_MAX);
    assign w_issue_ld = (r_state == S_HELD) && !bus.flush && !w_conflict && !w_full;
    assign w_issue_st = !w_issue_ld && (r_count != '0);
    assign w_push     = bus.commit_valid && (!w_full || w_issue_st);
    assign w_resp     = (r_state == S_WAIT) && bus.mem_valid && (bus.mem_rob == r_ld_rob);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_issue_st)
            w_count_nxt = r_count + (PTR_W+1)'(1);
        else if (!w_push && w_issue_st)
            w_count_nxt = r_count - (PTR_W+1)'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_sb_full  <= 1'b0;
            r_sb_empty <= 1'b1;
        end else begin
            if (w_push)     r_tail <= r_tail + PTR_W'(1);
            if (w_issue_st) r_head <= r_head + PTR_W'(1);
            r_count    <= w_count_nxt;
            r_sb_full  <= (w_count_nxt == CNT_MAX);
            r_sb_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_sb_addr[r_tail] <= bus.commit_addr;
            r_sb_data[r_tail] <= bus.commit_data;
            r_sb_sh[r_tail]   <= bus.commit_sh;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: if (bus.ld_req_valid && !bus.flush) begin
                w_accept    = 1'b1;
                w_state_nxt = S_HELD;
            end
            S_HELD: if (bus.flush) w_state_nxt = S_IDLE;
                    else if (w_issue_ld) w_state_nxt = S_WAIT;
            S_WAIT: if (w_resp) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ld_addr  <= '0;
            r_ld_func3 <= '0;
            r_ld_pd    <= '0;
            r_ld_rob   <= '0;
            r_squash   <= 1'b0;
            r_last_rob <= '1;
            r_dup_err  <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_data  <= '0;
            r_wb_pd    <= '0;
            r_wb_rob   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_ld_addr  <= bus.ld_addr;
                r_ld_func3 <= bus.ld_func3;
                r_ld_pd    <= bus.ld_pd;
                r_ld_rob   <= bus.ld_rob;
            end
            // A flush in WAIT cannot cancel the memory access, only its writeback.
            if (w_resp)
                r_squash <= 1'b0;
            else if ((r_state == S_WAIT) && bus.flush)
                r_squash <= 1'b1;
            if (w_issue_ld) begin
                if (r_ld_rob == r_last_rob) r_dup_err <= 1'b1;
                r_last_rob <= r_ld_rob;
            end
            r_wb_valid <= w_resp && !r_squash && !bus.flush;
            if (w_resp) begin
                r_wb_data <= bus.mem_data;
                r_wb_pd   <= r_ld_pd;
                r_wb_rob  <= r_ld_rob;
            end
        end
    end

    assign bus.sb_full      = r_sb_full;
    assign bus.sb_empty     = r_sb_empty;
    assign bus.ld_req_ready = (r_state == S_IDLE) && !bus.flush;
    assign bus.store_wb     = w_issue_st;
    assign bus.st_addr      = w_issue_st ? r_sb_addr[r_head] : '0;
    assign bus.st_data      = w_issue_st ? r_sb_data[r_head] : '0;
    assign bus.st_sh        = w_issue_st && r_sb_sh[r_head];
    assign bus.load_mem     = w_issue_ld;
    assign bus.mem_ld_addr  = w_issue_ld ? r_ld_addr  : '0;
    assign bus.mem_ld_func3 = w_issue_ld ? r_ld_func3 : '0;
    assign bus.mem_ld_rob   = w_issue_ld ? r_ld_rob   : '0;
    assign bus.wb_valid     = r_wb_valid;
    assign bus.wb_data      = r_wb_data;
    assign bus.wb_pd        = r_wb_pd;
    assign bus.wb_rob       = r_wb_rob;
    assign bus.dup_tag_err  = r_dup_err;
    assign o_dbg_state      = r_state;

    a_sb_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(bus.commit_valid && w_full && !w_issue_st));
endmodule

// File: tb/tb_mem_req_issuer.sv
// Bench for mem_req_issuer: directed scenarios plus randomized traffic checked
// against a queue/byte-array model of program-order memory.
module tb_mem_req_issuer;
    localparam int DEPTH = 4, ROB_W = 5, PREG_W = 7;

    logic clk = 1'b0, reset = 1'b1;
    logic [1:0] dbg_state;
    always #5 clk = ~clk;

    mem_req_issuer_if #(.ROB_W(ROB_W), .PREG_W(PREG_W)) bus();
    mem_req_issuer #(.SB_DEPTH(DEPTH), .ROB_W(ROB_W), .PREG_W(PREG_W)) dut (
        .clk(clk), .reset(reset), .bus(bus), .o_dbg_state(dbg_state));

    int n_checks = 0, n_err = 0;
    logic [64:0] exp_q[$];              // {sh, addr, data} of buffered stores
    logic [7:0]  mem_a[int];            // program-order memory (every commit)
    logic [7:0]  mem_p[int];            // memory as written by store_wb
    int m_ls;                           // 0 none, 1 held, 2 issued
    logic m_sq, m_wb_exp, m_dup, acc, saw_full, resp_pend;
    logic [31:0] m_addr, m_exp_data, m_wb_data, resp_data;
    logic [2:0] m_f3;
    logic [PREG_W-1:0] m_pd, m_wb_pd;
    logic [ROB_W-1:0] m_rob, m_wb_rob, m_last, resp_rob;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd(input bit arch, input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] v = '0;
        for (int i = 0; i < 4; i++) begin
            int k = int'(a) + i;
            if (arch) v[8*i +: 8] = mem_a.exists(k) ? mem_a[k] : 8'h00;
            else      v[8*i +: 8] = mem_p.exists(k) ? mem_p[k] : 8'h00;
        end
        return (f3 == 3'b100) ? {24'h0, v[7:0]} : v;
    endfunction

    task automatic wr(input bit arch, input logic [31:0] a, input logic [31:0] d, input logic sh);
        for (int i = 0; i < (sh ? 2 : 4); i++) begin
            if (arch) mem_a[int'(a) + i] = d[8*i +: 8];
            else      mem_p[int'(a) + i] = d[8*i +: 8];
        end
    endtask

    function automatic bit ov(input logic [31:0] la, input logic [2:0] f3,
                              input logic [31:0] sa, input logic sh);
        logic [31:0] l_end = la + ((f3 == 3'b010) ? 32'd3 : 32'd0);
        logic [31:0] s_end = sa + (sh ? 32'd1 : 32'd3);
        return (la <= s_end) && (sa <= l_end);
    endfunction

    // Monitor and reference model: checks the current cycle, then advances the model.
    always @(negedge clk) begin
        if (!reset) begin
            int sz; logic conf, exp_ld, exp_st, exp_rdy, wb_nxt; logic [64:0] e;
            sz = exp_q.size();
            conf = 1'b0;
            foreach (exp_q[i]) if (ov(m_addr, m_f3, exp_q[i][63:32], exp_q[i][64])) conf = 1'b1;
            exp_rdy = (m_ls == 0) && !bus.flush;
            exp_ld  = (m_ls == 1) && !bus.flush && !conf && (sz < DEPTH);
            exp_st  = !exp_ld && (sz != 0);
            check("sb_empty", bus.sb_empty, sz == 0);
            check("sb_full", bus.sb_full, sz == DEPTH);
            check("dup_tag_err", bus.dup_tag_err, m_dup);
            check("ld_req_ready", bus.ld_req_ready, exp_rdy);
            check("wb_valid", bus.wb_valid, m_wb_exp);
            if (m_wb_exp) begin
                check("wb_data", bus.wb_data, m_wb_data);
                check("wb_pd", bus.wb_pd, m_wb_pd);
                check("wb_rob", bus.wb_rob, m_wb_rob);
            end
            check("load_mem", bus.load_mem, exp_ld);
            check("store_wb", bus.store_wb, exp_st);
            if (sz == DEPTH && bus.store_wb && m_ls == 1) saw_full = 1'b1;
            if (bus.store_wb) wr(0, bus.st_addr, bus.st_data, bus.st_sh);
            if (bus.load_mem) begin
                resp_pend = 1'b1;
                resp_data = rd(0, bus.mem_ld_addr, bus.mem_ld_func3);
                resp_rob  = bus.mem_ld_rob;
            end
            if (exp_st) begin
                e = exp_q.pop_front();
                check("st_addr", bus.st_addr, e[63:32]);
                check("st_data", bus.st_data, e[31:0]);
                check("st_sh", bus.st_sh, e[64]);
            end
            wb_nxt = 1'b0;
            if (m_ls == 2 && bus.mem_valid && bus.mem_rob == m_rob) begin
                if (!m_sq && !bus.flush) begin
                    wb_nxt = 1'b1; m_wb_data = m_exp_data; m_wb_pd = m_pd; m_wb_rob = m_rob;
                end
                m_ls = 0; m_sq = 1'b0;
            end else if (m_ls == 2 && bus.flush) m_sq = 1'b1;
            if (exp_ld) begin
                check("mem_ld_addr", bus.mem_ld_addr, m_addr);
                check("mem_ld_func3", bus.mem_ld_func3, m_f3);
                check("mem_ld_rob", bus.mem_ld_rob, m_rob);
                m_exp_data = rd(1, m_addr, m_f3);
                if (m_rob == m_last) m_dup = 1'b1;
                m_last = m_rob; m_ls = 2;
            end else if (m_ls == 1 && bus.flush) m_ls = 0;
            if (exp_rdy && bus.ld_req_valid) begin
                m_ls = 1; m_addr = bus.ld_addr; m_f3 = bus.ld_func3;
                m_pd = bus.ld_pd; m_rob = bus.ld_rob; acc = 1'b1;
            end
            if (bus.commit_valid) begin
                if (sz - (exp_st ? 1 : 0) < DEPTH)
                    exp_q.push_back({bus.commit_sh, bus.commit_addr, bus.commit_data});
                wr(1, bus.commit_addr, bus.commit_data, bus.commit_sh);
            end
            m_wb_exp = wb_nxt;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
        bus.mem_valid = resp_pend;
        if (resp_pend) begin bus.mem_data = resp_data; bus.mem_rob = resp_rob; end
        resp_pend = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.flush = 0; bus.commit_valid = 0; bus.commit_addr = 0; bus.commit_data = 0;
        bus.commit_sh = 0; bus.commit_rob = 0; bus.ld_req_valid = 0; bus.ld_addr = 0;
        bus.ld_func3 = 0; bus.ld_pd = 0; bus.ld_rob = 0;
    endtask

    task automatic model_reset();
        exp_q.delete(); m_ls = 0; m_sq = 0; m_wb_exp = 0; m_dup = 0; m_last = '1;
        resp_pend = 0; acc = 0; bus.mem_valid = 0; mem_a = mem_p;
    endtask

    task automatic req(input logic [31:0] a, input logic [2:0] f3, input int pd, input int rob);
        bus.ld_req_valid = 1; bus.ld_addr = a; bus.ld_func3 = f3;
        bus.ld_pd = PREG_W'(pd); bus.ld_rob = ROB_W'(rob);
    endtask

    task automatic commit(input logic [31:0] a, input logic [31:0] d, input logic sh);
        bus.commit_valid = 1; bus.commit_addr = a; bus.commit_data = d; bus.commit_sh = sh;
        bus.commit_rob = ROB_W'($urandom_range(0, 31));
    endtask

    task automatic wait_wb(input string tag, input logic [31:0] exp);
        int n = 0;
        do begin tick(); #2; n++; end while (!bus.wb_valid && n < 20);
        check({tag, "_wb_seen"}, bus.wb_valid, 1);
        check({tag, "_wb_data"}, bus.wb_data, exp);
    endtask

    task automatic wait_quiet(input string tag);
        int n = 0; bit done = 0;
        while (!done && n < 100) begin
            tick(); n++;
            if (acc) begin acc = 0; bus.ld_req_valid = 0; end
            done = !bus.ld_req_valid && m_ls == 0 && exp_q.size() == 0 && !m_wb_exp;
        end
        check(tag, done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs(); bus.mem_data = 0; bus.mem_rob = 0; saw_full = 0;
        model_reset();
        repeat (2) @(posedge clk); #1;
        check("rst_store_wb", bus.store_wb, 0);
        check("rst_load_mem", bus.load_mem, 0);
        check("rst_wb_valid", bus.wb_valid, 0);
        check("rst_sb_empty", bus.sb_empty, 1);
        check("rst_sb_full", bus.sb_full, 0);
        check("rst_ready", bus.ld_req_ready, 1);
        check("rst_dup", bus.dup_tag_err, 0);
        wr(1, 32'h100, 32'hDEADBEEF, 0); wr(0, 32'h100, 32'hDEADBEEF, 0);
        reset = 0;
        tick();

        // Single lw: issue in cycle 1, writeback in cycle 3
        req(32'h100, 3'b010, 9, 3);
        tick(); bus.ld_req_valid = 0; #2;
        check("t1_load_mem", bus.load_mem, 1);
        check("t1_ld_addr", bus.mem_ld_addr, 32'h100);
        tick(); tick(); #2;
        check("t1_wb_valid", bus.wb_valid, 1);
        check("t1_wb_data", bus.wb_data, 32'hDEADBEEF);
        check("t1_wb_pd", bus.wb_pd, 9);
        check("t1_wb_rob", bus.wb_rob, 3);
        check("t1_ready", bus.ld_req_ready, 1);

        // Overlapping store drains before the load
        tick(); commit(32'h200, 32'h11223344, 0); req(32'h202, 3'b010, 10, 4);
        tick(); idle_inputs(); #2;
        check("t2_held_load", bus.load_mem, 0);
        check("t2_store_first", bus.store_wb, 1);
        tick(); #2;
        check("t2_load_after", bus.load_mem, 1);
        wait_wb("t2", 32'h00001122);

        // Disjoint sh/lbu: load goes ahead of the buffered store
        commit(32'h300, 32'h0000AABB, 1); req(32'h302, 3'b100, 11, 6);
        tick(); idle_inputs(); #2;
        check("t3_load_first", bus.load_mem, 1);
        check("t3_store_wait", bus.store_wb, 0);
        wait_wb("t3", 32'h0);
        wait_quiet("t3_quiet");

        // Continuous commits with back-to-back loads fill the buffer
        acc = 0; saw_full = 0;
        for (int k = 0; k < 30; k++) begin
            commit(32'h400 + 32'(4 * k), $urandom, 0);
            if (acc) begin acc = 0; bus.ld_req_valid = 0; end
            else if (!bus.ld_req_valid) req(32'h500, 3'b100, 20 + k, 10 + k);
            tick();
        end
        bus.commit_valid = 0;
        wait_quiet("t4_quiet");
        check("t4_saw_full", saw_full, 1);

        // Flush coinciding with the response
        req(32'h100, 3'b010, 12, 5);
        tick(); bus.ld_req_valid = 0;
        tick(); bus.flush = 1;
        tick(); bus.flush = 0; #2;
        check("t5_no_wb", bus.wb_valid, 0);
        check("t5_ready", bus.ld_req_ready, 1);

        // Same tag issued twice in a row
        req(32'h120, 3'b100, 13, 7);
        tick(); bus.ld_req_valid = 0;
        wait_wb("t6a", 32'h0);
        check("t6_dup_before", bus.dup_tag_err, 0);
        req(32'h124, 3'b100, 14, 7);
        tick(); bus.ld_req_valid = 0;
        wait_wb("t6b", 32'h0);
        check("t6_dup_set", bus.dup_tag_err, 1);
        tick(); tick(); #2;
        check("t6_dup_sticky", bus.dup_tag_err, 1);

        // Randomized traffic with a reset in the middle
        acc = 0;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (acc) begin acc = 0; bus.ld_req_valid = 0; end
            if (c == 200) begin
                reset = 1; idle_inputs(); #1;
                check("mid_rst_store_wb", bus.store_wb, 0);
                check("mid_rst_load_mem", bus.load_mem, 0);
                check("mid_rst_sb_empty", bus.sb_empty, 1);
                check("mid_rst_wb_valid", bus.wb_valid, 0);
                check("mid_rst_dup", bus.dup_tag_err, 0);
                model_reset();
                @(posedge clk); #1; reset = 0;
            end else begin
                if ($urandom_range(0, 2) == 0)
                    commit(32'h100 + 32'($urandom_range(0, 40)), $urandom, 1'($urandom_range(0, 1)));
                else bus.commit_valid = 0;
                bus.flush = ($urandom_range(0, 15) == 0);
                if (!bus.ld_req_valid && $urandom_range(0, 1) == 1)
                    req(32'h100 + 32'($urandom_range(0, 40)),
                        ($urandom_range(0, 1) == 1) ? 3'b010 : 3'b100,
                        $urandom_range(0, 127), $urandom_range(0, 31));
            end
        end
        bus.commit_valid = 0; bus.flush = 0;
        wait_quiet("rand_quiet");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
